ahbl_sram_ctrl: RTL and testbench

Zero-wait-state AHB-Lite slave that turns bus transfers into single-port synchronous SRAM accesses for the 3K x 32 system RAM. It sits in the S1 slot between the AHB-Lite decoder/mux and `RAM_3Kx32`. A one-entry posted-write buffer and read forwarding keep `HREADYOUT` permanently high, including read-after-write and back-to-back mixed traffic.

---
 rtl/ahbl_pkg.sv | 43 ++++
 rtl/ahbl_sram_ctrl_if.sv | 23 ++
 rtl/ahbl_sram_wbuf.sv | 42 ++++
 rtl/ahbl_sram_ctrl.sv | 142 ++++++++++++++
 tb/tb_ahbl_sram_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer encodings, byte-lane types and
// the byte-enable / byte-merge helpers used by the SRAM controller.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef logic [NUM_LANES-1:0]             be_t;
    typedef logic [NUM_LANES-1:0][LANE_W-1:0] word_t;

    // Byte lanes touched by a transfer; anything wider than a half is a word.
    function automatic be_t ahbl_be(input logic [2:0] hsize, input logic [1:0] addr_lo);
        be_t be;
        case (hsize)
            HSIZE_BYTE: be = be_t'(4'b0001) << addr_lo;
            HSIZE_HALF: be = be_t'(4'b0011) << {addr_lo[1], 1'b0};
            default:    be = '1;
        endcase
        return be;
    endfunction

    // Per-lane select: lanes set in be come from upd, the rest from base.
    function automatic word_t ahbl_merge(input word_t base, input word_t upd, input be_t be);
        word_t r;
        for (int i = 0; i < NUM_LANES; i++)
            r[i] = be[i] ? upd[i] : base[i];
        return r;
    endfunction

endpackage

// File: rtl/ahbl_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the SRAM controller.
interface ahbl_sram_ctrl_if;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahbl_sram_wbuf.sv
// One-entry posted-write buffer. Holds a write that lost the SRAM port to a
// read and reports which of its bytes cover a given word address.
module ahbl_sram_wbuf
    import ahbl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  be_t           load_be,
    input  word_t         load_data,
    input  logic          drain,
    input  logic [AW-1:0] match_addr,
    output logic          valid,
    output logic [AW-1:0] addr,
    output be_t           be,
    output word_t         data,
    output be_t           hit_be
);

    // Load wins over drain; the controller never requests both together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            be    <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            be    <= load_be;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    assign hit_be = (valid && addr == match_addr) ? be : '0;

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// Zero-wait-state AHB-Lite to single-port synchronous SRAM bridge.
// Reads own the SRAM port in their address phase; a write whose data phase
// collides with a read is parked in a one-entry buffer and drained on the
// next cycle without a read. Reads see pending writes through forwarding.
module ahbl_sram_ctrl
    import ahbl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahbl_sram_ctrl_if.slave       ahb,
    input  logic [31:0]           SRAMRDATA,
    output logic                  SRAMCS0,
    output logic [3:0]            SRAMWEN,
    output logic [31:0]           SRAMWDATA,
    output logic [AW-1:0]         SRAMADDR
);

    // Address-phase decode
    logic          addr_ph, rd_ph, wr_ph;
    logic [AW-1:0] ha;
    be_t           hbe;

    assign addr_ph = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign rd_ph   = addr_ph & ~ahb.HWRITE;
    assign wr_ph   = addr_ph &  ahb.HWRITE;
    assign ha      = ahb.HADDR[AW+1:2];
    assign hbe     = ahbl_be(ahb.HSIZE, ahb.HADDR[1:0]);

    // Upper address bits wrap; HTRANS[0] only separates IDLE from BUSY.
    logic unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:AW+2], ahb.HTRANS[0]};

    // Data-phase and forwarding state
    logic          dp_wr, dp_rd;
    logic [AW-1:0] dp_addr;
    be_t           dp_be;
    be_t           fwd_be;
    word_t         fwd_data;
    word_t         hrdata_q;

    // Write buffer
    logic          wb_valid, wb_load, wb_drain;
    logic [AW-1:0] wb_addr;
    be_t           wb_be, wb_hit_be;
    word_t         wb_data;

    assign wb_load  = dp_wr & rd_ph;
    assign wb_drain = wb_valid & ~rd_ph;

    ahbl_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk        (HCLK),
        .rst        (HRESET),
        .load       (wb_load),
        .load_addr  (dp_addr),
        .load_be    (dp_be),
        .load_data  (ahb.HWDATA),
        .drain      (wb_drain),
        .match_addr (ha),
        .valid      (wb_valid),
        .addr       (wb_addr),
        .be         (wb_be),
        .data       (wb_data),
        .hit_be     (wb_hit_be)
    );

    // Forwarding sources for the read in its address phase; the in-flight
    // data-phase write is younger than the buffer, so its bytes win.
    be_t   dp_hit_be, fwd_be_d;
    word_t fwd_data_d;

    assign dp_hit_be  = (dp_wr && dp_addr == ha) ? dp_be : '0;
    assign fwd_be_d   = wb_hit_be | dp_hit_be;
    assign fwd_data_d = ahbl_merge(wb_data, ahb.HWDATA, dp_hit_be);

    // Capture address-phase attributes into the data phase
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_wr   <= 1'b0;
            dp_rd   <= 1'b0;
            dp_addr <= '0;
            dp_be   <= '0;
        end else begin
            dp_wr <= wr_ph;
            dp_rd <= rd_ph;
            if (addr_ph) begin
                dp_addr <= ha;
                dp_be   <= hbe;
            end
        end
    end

    // Register the forwarding mask/data for the read data phase
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fwd_be   <= '0;
            fwd_data <= '0;
        end else if (rd_ph) begin
            fwd_be   <= fwd_be_d;
            fwd_data <= fwd_data_d;
        end
    end

    // SRAM port arbitration: read > buffer drain > direct write
    always_comb begin
        SRAMCS0   = 1'b0;
        SRAMWEN   = '0;
        SRAMWDATA = '0;
        SRAMADDR  = '0;
        if (!HRESET) begin
            if (rd_ph) begin
                SRAMCS0  = 1'b1;
                SRAMADDR = ha;
            end else if (wb_valid) begin
                SRAMCS0   = 1'b1;
                SRAMWEN   = wb_be;
                SRAMWDATA = wb_data;
                SRAMADDR  = wb_addr;
            end else if (dp_wr) begin
                SRAMCS0   = 1'b1;
                SRAMWEN   = dp_be;
                SRAMWDATA = ahb.HWDATA;
                SRAMADDR  = dp_addr;
            end
        end
    end

    // Read data: forwarded bytes over SRAM bytes, held between reads
    word_t rd_merged;
    assign rd_merged = ahbl_merge(SRAMRDATA, fwd_data, fwd_be);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)     hrdata_q <= '0;
        else if (dp_rd) hrdata_q <= rd_merged;
    end

    assign ahb.HRDATA    = dp_rd ? rd_merged : hrdata_q;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Bench for ahbl_sram_ctrl: directed scenarios plus random traffic, checked
// against a byte-addressed memory model updated in bus program order.
module tb_ahbl_sram_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] SRAMRDATA;
    logic        SRAMCS0;
    logic [3:0]  SRAMWEN;
    logic [31:0] SRAMWDATA;
    logic [11:0] SRAMADDR;

    always #5 HCLK = ~HCLK;

    ahbl_sram_ctrl_if bus();

    ahbl_sram_ctrl #(.AW(12)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .ahb       (bus),
        .SRAMRDATA (SRAMRDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMADDR  (SRAMADDR)
    );

    // Synchronous SRAM: byte-enabled write, registered read
    logic [31:0] sram [4096];
    logic [31:0] sram_w;
    always @(posedge HCLK) begin
        if (SRAMCS0) begin
            if (SRAMWEN != 4'b0000) begin
                sram_w = sram[SRAMADDR];
                for (int b = 0; b < 4; b++)
                    if (SRAMWEN[b]) sram_w[8*b +: 8] = SRAMWDATA[8*b +: 8];
                sram[SRAMADDR] <= sram_w;
            end else begin
                SRAMRDATA <= sram[SRAMADDR];
            end
        end
    end

    // Reference model: flat byte memory, 16 KB window (address wraps)
    logic [7:0] ref_mem [16384];

    int checks   = 0;
    int failures = 0;

    bit          prev_rd = 1'b0;
    bit          prev_wr = 1'b0;
    logic [31:0] prev_wdata = '0;
    logic [31:0] prev_exp   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        return (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = int'(a[13:0]) & ~3;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[base + k];
        return w;
    endfunction

    // A transfer of n bytes covers the n-aligned byte run holding the address
    function automatic logic [3:0] ref_lanes(input logic [31:0] a, input logic [2:0] sz);
        logic [3:0] m;
        int n, start;
        n = nbytes(sz);
        start = int'(a[1:0]) & ~(n - 1);
        m = '0;
        for (int k = 0; k < 4; k++) m[k] = (k >= start) && (k < start + n);
        return m;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        logic [3:0] m;
        int base;
        m = ref_lanes(a, sz);
        base = int'(a[13:0]) & ~3;
        for (int k = 0; k < 4; k++)
            if (m[k]) ref_mem[base + k] = wd[8*k +: 8];
    endtask

    // Present one address phase (and the previous write's data), with checks
    task automatic drive(input bit sel, input bit rdy, input logic [1:0] tr, input bit wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        bit acc;
        @(negedge HCLK);
        if (prev_rd) chk("rdata", bus.HRDATA, prev_exp);
        chk("hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("hresp", 32'(bus.HRESP), 32'd0);
        bus.HWDATA = prev_wr ? prev_wdata : $urandom();
        bus.HSEL   = sel;
        bus.HREADY = rdy;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
        bus.HADDR  = a;
        acc = sel & rdy & tr[1];
        #1;
        if (acc && !wr) begin
            chk("rd_cs", 32'(SRAMCS0), 32'd1);
            chk("rd_wen", 32'(SRAMWEN), 32'd0);
            chk("rd_addr", 32'(SRAMADDR), 32'(a[13:2]));
        end else if (SRAMCS0) begin
            chk("nonread_access_is_write", 32'(SRAMWEN != 4'b0000), 32'd1);
        end
        chk("wb_dp_exclusive", 32'(dut.u_wbuf.valid & dut.dp_wr), 32'd0);
        prev_rd = acc && !wr;
        prev_wr = acc && wr;
        if (acc && !wr) prev_exp = ref_read(a);
        if (acc && wr) begin
            ref_write(a, sz, wd);
            prev_wdata = wd;
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
    endtask

    task automatic step(input bit sel, input bit rdy, input logic [1:0] tr, input bit wr,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        drive(sel, rdy, tr, wr, sz, a, wd);
        tick();
    endtask

    task automatic wr_step(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        step(1'b1, 1'b1, 2'b10, 1'b1, sz, a, wd);
    endtask

    task automatic rd_step(input logic [31:0] a);
        step(1'b1, 1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0);
    endtask

    task automatic idle_drive();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic idle_step();
        idle_drive();
        tick();
    endtask

    int          kind, n;
    logic [2:0]  sz;
    logic [31:0] a, d, old;

    initial begin
        for (int i = 0; i < 4096; i++)  sram[i] = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = '0;

        // Reset state
        HRESET     = 1'b1;
        bus.HSEL   = 1'b0;
        bus.HREADY = 1'b1;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HADDR  = '0;
        bus.HWDATA = '0;
        #1;
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(bus.HRESP), 32'd0);
        chk("rst_cs", 32'(SRAMCS0), 32'd0);
        chk("rst_wen", 32'(SRAMWEN), 32'd0);
        chk("rst_wdata", SRAMWDATA, 32'h0);
        chk("rst_addr", 32'(SRAMADDR), 32'h0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK) HRESET = 1'b0;

        // 1: direct word write, then read back; HRDATA holds afterwards
        wr_step(3'd2, 32'h10, 32'hDEADBEEF);
        idle_drive();
        chk("t1_wr_cs", 32'(SRAMCS0), 32'd1);
        chk("t1_wr_wen", 32'(SRAMWEN), 32'hF);
        chk("t1_wr_addr", 32'(SRAMADDR), 32'h4);
        chk("t1_wr_data", SRAMWDATA, 32'hDEADBEEF);
        tick();
        rd_step(32'h10);
        idle_drive();
        chk("t1_rdata", bus.HRDATA, 32'hDEADBEEF);
        tick();
        idle_drive();
        chk("t1_rdata_hold", bus.HRDATA, 32'hDEADBEEF);
        tick();

        // 2: write immediately followed by read of same word -> posted + forwarded
        wr_step(3'd2, 32'h20, 32'h11223344);
        rd_step(32'h20);
        idle_drive();
        chk("t2_rdata_fwd", bus.HRDATA, 32'h11223344);
        chk("t2_wb_valid", 32'(dut.u_wbuf.valid), 32'd1);
        chk("t2_drain_cs", 32'(SRAMCS0), 32'd1);
        chk("t2_drain_wen", 32'(SRAMWEN), 32'hF);
        chk("t2_drain_addr", 32'(SRAMADDR), 32'h8);
        chk("t2_drain_data", SRAMWDATA, 32'h11223344);
        tick();
        idle_drive();
        chk("t2_wb_empty", 32'(dut.u_wbuf.valid), 32'd0);
        tick();

        // 3: byte and half-word writes merged into a zeroed word
        wr_step(3'd2, 32'h30, 32'h0);
        idle_step();
        wr_step(3'd0, 32'h31, 32'h0000AA00);
        idle_drive();
        chk("t3_byte_wen", 32'(SRAMWEN), 32'b0010);
        tick();
        wr_step(3'd1, 32'h32, 32'hBBCC0000);
        idle_drive();
        chk("t3_half_wen", 32'(SRAMWEN), 32'b1100);
        tick();
        rd_step(32'h30);
        idle_drive();
        chk("t3_rdata", bus.HRDATA, 32'hBBCCAA00);
        tick();

        // 4: alternating write/read over ten words
        for (int i = 0; i < 10; i++) begin
            a = 32'h100 + 32'(i * 4);
            wr_step(3'd2, a, $urandom());
            rd_step(a);
        end
        // posted word partially overwritten by a later byte write
        wr_step(3'd2, 32'h10C, $urandom());
        rd_step(32'h10C);
        wr_step(3'd0, 32'h10E, $urandom());
        rd_step(32'h10C);
        // read of a word still sitting in the buffer
        wr_step(3'd2, 32'h110, $urandom());
        rd_step(32'h114);
        rd_step(32'h110);
        // aliased address above the SRAM window
        wr_step(3'd2, 32'hFFFF_C050, 32'h5A5A_A5A5);
        rd_step(32'h50);
        idle_step();
        rd_step(32'h50);
        idle_step();

        // 5: reset while a write is posted discards it
        wr_step(3'd2, 32'h200, 32'hCAFEF00D);
        idle_step();
        old = ref_read(32'h200);
        wr_step(3'd2, 32'h200, 32'h12345678);
        rd_step(32'h204);
        @(negedge HCLK);
        chk("t5_wb_valid", 32'(dut.u_wbuf.valid), 32'd1);
        HRESET = 1'b1;
        #1;
        chk("t5_rst_cs", 32'(SRAMCS0), 32'd0);
        chk("t5_rst_wen", 32'(SRAMWEN), 32'd0);
        chk("t5_rst_hrdata", bus.HRDATA, 32'h0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        HRESET     = 1'b0;
        prev_rd    = 1'b0;
        prev_wr    = 1'b0;
        ref_write(32'h200, 3'd2, old);
        rd_step(32'h200);
        idle_drive();
        chk("t5_old_data", bus.HRDATA, 32'hCAFEF00D);
        tick();

        // 6: random traffic with unselected, BUSY and HREADY-low cycles
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 9);
            sz   = 3'($urandom_range(0, 2));
            n    = nbytes(sz);
            a    = 32'h400 + 32'($urandom_range(0, 15) * 4);
            a[1:0] = 2'($urandom_range(0, 3) & ~(n - 1));
            if ($urandom_range(0, 3) == 0) a = a | (32'h4000 << $urandom_range(0, 17));
            d = $urandom();
            if (kind <= 3)
                wr_step(sz, a, d);
            else if (kind <= 6)
                step(1'b1, 1'b1, 2'b10, 1'b0, sz, a, 32'h0);
            else if (kind == 7)
                step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), sz, a, d);
            else if (kind == 8)
                step(1'b1, 1'b1, 2'b01, 1'($urandom_range(0, 1)), sz, a, d);
            else if (!prev_rd && !prev_wr)
                step(1'b1, 1'b0, 2'b10, 1'($urandom_range(0, 1)), sz, a, d);
            else
                idle_step();
        end
        idle_step();
        idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
